// File: rtl/hdc_pipeline_controller_pkg.sv
// Shared definitions for the HDC pipeline controller.
// Contents: controller state encoding, mode constants, the ceil_log2 helper
// and the default NGRAM_SIZE / LABEL_WIDTH values.
package hdc_pipeline_controller_pkg;

    localparam int DEFAULT_NGRAM_SIZE  = 4;
    localparam int DEFAULT_LABEL_WIDTH = 3;

    localparam logic MODE_PREDICT = 1'b0;
    localparam logic MODE_TRAIN   = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SPAT_WAIT = 3'd2,
        ST_AM_REQ    = 3'd3,
        ST_AM_WAIT   = 3'd4,
        ST_OUT       = 3'd5
    } state_t;

    // Smallest n with 2**n >= value (value >= 1).
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hdc_pipeline_controller_ngram_fill_counter.sv
// Saturating fill counter for the N-gram window.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clr              clear count to 0 (wins over inc)
//   inc              saturating increment towards NGRAM_SIZE
//   full             count == NGRAM_SIZE
//   almost_full      count == NGRAM_SIZE-1 (next increment fills the window)
module ngram_fill_counter
    import hdc_pipeline_controller_pkg::*;
#(
    parameter int NGRAM_SIZE = DEFAULT_NGRAM_SIZE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic full,
    output logic almost_full
);

    localparam int CNT_W = ceil_log2(NGRAM_SIZE + 1);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != FILL_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign full        = (count == FILL_MAX);
    assign almost_full = (count == FILL_MAX - 1'b1);

endmodule

// File: rtl/hdc_pipeline_controller.sv
// Control sequencer for the HDC gesture pipeline
// (spatial encoder -> N-gram temporal encoder -> associative memory).
// Sample data bypasses this block; it owns handshakes, mode and label only.
// Ports:
//   Clk_CI, Reset_RI                 clock, synchronous active-high reset
//   ValidIn_SI/ReadyOut_SO           upstream sample handshake (+ModeIn_SI, LabelIn_DI)
//   SpatValidOut_SO/SpatReadyIn_SI   sample request to spatial encoder
//   SpatValidIn_SI/SpatReadyOut_SO   spatial hypervector ready from encoder
//   TempShiftEN_SO, TempCLR_SO       N-gram shift / history clear pulses
//   AMValidOut_SO/AMReadyIn_SI       AM request (+AMTrainEN_SO, AMLabelOut_DO)
//   AMValidIn_SI/AMReadyOut_SO       AM query result (+AMLabelIn_DI)
//   ValidOut_SO/ReadyIn_SI           downstream prediction (+LabelOut_DO)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// INIT       | first cycle out of reset: flush N-gram history, clear fill
// IDLE       | pass upstream sample handshake through to spatial encoder
// SPAT_WAIT  | wait for spatial HV, shift it into the N-gram
// AM_REQ     | present train/query request to AM
// AM_WAIT    | wait for AM predicted label
// OUT        | present predicted label downstream
module hdc_pipeline_controller
    import hdc_pipeline_controller_pkg::*;
#(
    parameter int NGRAM_SIZE  = DEFAULT_NGRAM_SIZE,
    parameter int LABEL_WIDTH = DEFAULT_LABEL_WIDTH
) (
    input  logic                   Clk_CI,
    input  logic                   Reset_RI,
    input  logic                   ValidIn_SI,
    output logic                   ReadyOut_SO,
    input  logic                   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0] LabelIn_DI,
    output logic                   SpatValidOut_SO,
    input  logic                   SpatReadyIn_SI,
    input  logic                   SpatValidIn_SI,
    output logic                   SpatReadyOut_SO,
    output logic                   TempShiftEN_SO,
    output logic                   TempCLR_SO,
    output logic                   AMValidOut_SO,
    input  logic                   AMReadyIn_SI,
    output logic                   AMTrainEN_SO,
    output logic [LABEL_WIDTH-1:0] AMLabelOut_DO,
    input  logic                   AMValidIn_SI,
    input  logic [LABEL_WIDTH-1:0] AMLabelIn_DI,
    output logic                   AMReadyOut_SO,
    output logic                   ValidOut_SO,
    input  logic                   ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0] LabelOut_DO
);

    state_t                 state, state_next;
    logic                   mode_reg;
    logic [LABEL_WIDTH-1:0] label_reg;
    logic                   fill_clr, fill_inc, fill_full, fill_almost_full;
    logic                   latch_sample, load_label, temp_clr;

    ngram_fill_counter #(
        .NGRAM_SIZE (NGRAM_SIZE)
    ) u_fill (
        .clk         (Clk_CI),
        .rst         (Reset_RI),
        .clr         (fill_clr),
        .inc         (fill_inc),
        .full        (fill_full),
        .almost_full (fill_almost_full)
    );

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state       <= ST_INIT;
            mode_reg    <= MODE_PREDICT;
            label_reg   <= '0;
            LabelOut_DO <= '0;
        end else begin
            state <= state_next;
            if (latch_sample) begin
                mode_reg  <= ModeIn_SI;
                label_reg <= LabelIn_DI;
            end
            if (load_label) begin
                LabelOut_DO <= AMLabelIn_DI;
            end
        end
    end

    always_comb begin
        state_next      = state;
        ReadyOut_SO     = 1'b0;
        SpatValidOut_SO = 1'b0;
        SpatReadyOut_SO = 1'b0;
        TempShiftEN_SO  = 1'b0;
        temp_clr        = 1'b0;
        AMValidOut_SO   = 1'b0;
        AMTrainEN_SO    = 1'b0;
        AMLabelOut_DO   = '0;
        AMReadyOut_SO   = 1'b0;
        ValidOut_SO     = 1'b0;
        fill_clr        = 1'b0;
        fill_inc        = 1'b0;
        latch_sample    = 1'b0;
        load_label      = 1'b0;

        case (state)
            ST_INIT: begin
                temp_clr   = 1'b1;
                fill_clr   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                ReadyOut_SO     = SpatReadyIn_SI;
                SpatValidOut_SO = ValidIn_SI;
                if (ValidIn_SI && SpatReadyIn_SI) begin
                    latch_sample = 1'b1;
                    // Train and predict windows must not mix history.
                    if (ModeIn_SI != mode_reg) begin
                        temp_clr = 1'b1;
                        fill_clr = 1'b1;
                    end
                    state_next = ST_SPAT_WAIT;
                end
            end
            ST_SPAT_WAIT: begin
                SpatReadyOut_SO = 1'b1;
                if (SpatValidIn_SI) begin
                    TempShiftEN_SO = 1'b1;
                    fill_inc       = 1'b1;
                    // Once full the window slides: every new HV triggers a request.
                    state_next = (fill_full || fill_almost_full) ? ST_AM_REQ : ST_IDLE;
                end
            end
            ST_AM_REQ: begin
                AMValidOut_SO = 1'b1;
                AMTrainEN_SO  = (mode_reg == MODE_TRAIN);
                AMLabelOut_DO = label_reg;
                if (AMReadyIn_SI) begin
                    state_next = (mode_reg == MODE_TRAIN) ? ST_IDLE : ST_AM_WAIT;
                end
            end
            ST_AM_WAIT: begin
                AMReadyOut_SO = 1'b1;
                if (AMValidIn_SI) begin
                    load_label = 1'b1;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The state register sits in INIT while reset is held; gating keeps the
    // flush to a single pulse on the first cycle after reset is released.
    assign TempCLR_SO = temp_clr && !Reset_RI;

endmodule

// File: tb/tb_hdc_pipeline_controller.sv
module tb_hdc_pipeline_controller;

    localparam int NGRAM = 4;
    localparam int LW    = 3;

    typedef struct packed {
        logic          train;
        logic [LW-1:0] label;
    } am_req_t;

    logic          Clk_CI = 1'b0;
    logic          Reset_RI = 1'b1;
    logic          ValidIn_SI = 1'b0;
    logic          ReadyOut_SO;
    logic          ModeIn_SI = 1'b0;
    logic [LW-1:0] LabelIn_DI = '0;
    logic          SpatValidOut_SO;
    logic          SpatReadyIn_SI = 1'b0;
    logic          SpatValidIn_SI = 1'b0;
    logic          SpatReadyOut_SO;
    logic          TempShiftEN_SO;
    logic          TempCLR_SO;
    logic          AMValidOut_SO;
    logic          AMReadyIn_SI = 1'b0;
    logic          AMTrainEN_SO;
    logic [LW-1:0] AMLabelOut_DO;
    logic          AMValidIn_SI = 1'b0;
    logic [LW-1:0] AMLabelIn_DI = '0;
    logic          AMReadyOut_SO;
    logic          ValidOut_SO;
    logic          ReadyIn_SI = 1'b0;
    logic [LW-1:0] LabelOut_DO;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          mdl_mode = 1'b0;
    int            mdl_fill = 0;
    am_req_t       am_q[$];
    logic [LW-1:0] out_q[$];

    hdc_pipeline_controller #(
        .NGRAM_SIZE  (NGRAM),
        .LABEL_WIDTH (LW)
    ) dut (
        .Clk_CI          (Clk_CI),
        .Reset_RI        (Reset_RI),
        .ValidIn_SI      (ValidIn_SI),
        .ReadyOut_SO     (ReadyOut_SO),
        .ModeIn_SI       (ModeIn_SI),
        .LabelIn_DI      (LabelIn_DI),
        .SpatValidOut_SO (SpatValidOut_SO),
        .SpatReadyIn_SI  (SpatReadyIn_SI),
        .SpatValidIn_SI  (SpatValidIn_SI),
        .SpatReadyOut_SO (SpatReadyOut_SO),
        .TempShiftEN_SO  (TempShiftEN_SO),
        .TempCLR_SO      (TempCLR_SO),
        .AMValidOut_SO   (AMValidOut_SO),
        .AMReadyIn_SI    (AMReadyIn_SI),
        .AMTrainEN_SO    (AMTrainEN_SO),
        .AMLabelOut_DO   (AMLabelOut_DO),
        .AMValidIn_SI    (AMValidIn_SI),
        .AMLabelIn_DI    (AMLabelIn_DI),
        .AMReadyOut_SO   (AMReadyOut_SO),
        .ValidOut_SO     (ValidOut_SO),
        .ReadyIn_SI      (ReadyIn_SI),
        .LabelOut_DO     (LabelOut_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_am_valid"},   32'(AMValidOut_SO),   0);
        check_val({tag, "_am_ready"},   32'(AMReadyOut_SO),   0);
        check_val({tag, "_valid_out"},  32'(ValidOut_SO),     0);
        check_val({tag, "_shift"},      32'(TempShiftEN_SO),  0);
        check_val({tag, "_spat_ready"}, 32'(SpatReadyOut_SO), 0);
        check_val({tag, "_label_out"},  32'(LabelOut_DO),     0);
    endtask

    // One sample through the pipeline. Encoder answers after one idle cycle.
    task automatic send_sample(input logic mode, input logic [LW-1:0] label,
                               input logic [LW-1:0] am_label, input int up_stall,
                               input int am_stall, input int out_stall, input bit abort);
        bit            exp_clr;
        bit            exp_req;
        am_req_t       exp_am;
        logic [LW-1:0] exp_out;

        exp_clr = (mode != mdl_mode);
        if (exp_clr) mdl_fill = 0;
        mdl_mode = mode;
        if (mdl_fill < NGRAM) mdl_fill++;
        exp_req = (mdl_fill == NGRAM);
        if (exp_req) begin
            am_q.push_back('{train: mode, label: label});
            if (mode == 1'b0) out_q.push_back(am_label);
        end

        for (int i = 0; i < up_stall; i++) begin
            @(negedge Clk_CI);
            ValidIn_SI = 1'b1; ModeIn_SI = mode; LabelIn_DI = label; SpatReadyIn_SI = 1'b0;
            #1;
            check_val("up_ready_stall", 32'(ReadyOut_SO), 0);
            check_val("spat_valid_stall", 32'(SpatValidOut_SO), 1);
            check_val("clr_no_xfer", 32'(TempCLR_SO), 0);
        end
        @(negedge Clk_CI);
        ValidIn_SI = 1'b1; ModeIn_SI = mode; LabelIn_DI = label; SpatReadyIn_SI = 1'b1;
        #1;
        check_val("up_ready", 32'(ReadyOut_SO), 1);
        check_val("spat_valid", 32'(SpatValidOut_SO), 1);
        check_val("clr_mode_change", 32'(TempCLR_SO), 32'(exp_clr));

        @(negedge Clk_CI);
        ValidIn_SI = 1'b0;
        #1;
        check_val("up_ready_busy", 32'(ReadyOut_SO), 0);
        check_val("spat_ready_out", 32'(SpatReadyOut_SO), 1);
        check_val("shift_early", 32'(TempShiftEN_SO), 0);

        @(negedge Clk_CI);
        SpatValidIn_SI = 1'b1;
        #1;
        check_val("shift_en", 32'(TempShiftEN_SO), 1);
        check_val("clr_on_shift", 32'(TempCLR_SO), 0);

        @(negedge Clk_CI);
        SpatValidIn_SI = 1'b0;
        #1;
        check_val("am_req_valid", 32'(AMValidOut_SO), 32'(exp_req));
        if (!exp_req) begin
            check_val("idle_ready", 32'(ReadyOut_SO), 1);
            check_val("idle_valid_out", 32'(ValidOut_SO), 0);
            return;
        end

        exp_am = am_q.pop_front();
        check_val("am_train", 32'(AMTrainEN_SO), 32'(exp_am.train));
        check_val("am_label", 32'(AMLabelOut_DO), 32'(exp_am.label));
        for (int i = 0; i < am_stall; i++) begin
            @(negedge Clk_CI);
            AMReadyIn_SI = 1'b0;
            #1;
            check_val("am_valid_hold", 32'(AMValidOut_SO), 1);
            check_val("am_label_hold", 32'(AMLabelOut_DO), 32'(exp_am.label));
            check_val("up_ready_am", 32'(ReadyOut_SO), 0);
        end
        @(negedge Clk_CI);
        AMReadyIn_SI = 1'b1;
        #1;
        check_val("am_valid_xfer", 32'(AMValidOut_SO), 1);
        @(negedge Clk_CI);
        AMReadyIn_SI = 1'b0;
        #1;
        check_val("am_valid_after", 32'(AMValidOut_SO), 0);
        if (exp_am.train) begin
            check_val("train_no_out", 32'(ValidOut_SO), 0);
            check_val("train_idle_ready", 32'(ReadyOut_SO), 1);
            return;
        end

        check_val("am_ready_out", 32'(AMReadyOut_SO), 1);
        exp_out = out_q.pop_front();
        if (abort) begin
            Reset_RI = 1'b1;
            @(negedge Clk_CI);
            Reset_RI = 1'b0;
            #1;
            check_reset_outputs("abort");
            check_val("abort_init_clr", 32'(TempCLR_SO), 1);
            mdl_mode = 1'b0;
            mdl_fill = 0;
            return;
        end
        AMValidIn_SI = 1'b1;
        AMLabelIn_DI = am_label;
        @(negedge Clk_CI);
        AMValidIn_SI = 1'b0;
        AMLabelIn_DI = '0;
        #1;
        check_val("valid_out", 32'(ValidOut_SO), 1);
        check_val("label_out", 32'(LabelOut_DO), 32'(exp_out));
        for (int i = 0; i < out_stall; i++) begin
            @(negedge Clk_CI);
            ReadyIn_SI = 1'b0;
            #1;
            check_val("valid_out_hold", 32'(ValidOut_SO), 1);
            check_val("label_out_hold", 32'(LabelOut_DO), 32'(exp_out));
            check_val("up_ready_out", 32'(ReadyOut_SO), 0);
        end
        @(negedge Clk_CI);
        ReadyIn_SI = 1'b1;
        #1;
        check_val("valid_out_xfer", 32'(ValidOut_SO), 1);
        @(negedge Clk_CI);
        ReadyIn_SI = 1'b0;
        #1;
        check_val("valid_out_done", 32'(ValidOut_SO), 0);
        check_val("out_idle_ready", 32'(ReadyOut_SO), 1);
    endtask

    initial begin
        // Held reset: everything quiet, no flush yet.
        repeat (3) begin
            @(negedge Clk_CI);
            #1;
            check_reset_outputs("rst");
            check_val("rst_clr", 32'(TempCLR_SO), 0);
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        #1;
        check_val("init_clr", 32'(TempCLR_SO), 1);
        check_val("init_ready", 32'(ReadyOut_SO), 0);
        @(negedge Clk_CI);
        SpatReadyIn_SI = 1'b0;
        #1;
        check_val("idle_clr_once", 32'(TempCLR_SO), 0);
        check_val("ready_track0", 32'(ReadyOut_SO), 0);
        check_reset_outputs("idle");
        @(negedge Clk_CI);
        SpatReadyIn_SI = 1'b1;
        #1;
        check_val("ready_track1", 32'(ReadyOut_SO), 1);

        // Predict: fill window, then sliding requests, then backpressure.
        send_sample(1'b0, 3'd1, 3'd0, 1, 0, 0, 0);
        send_sample(1'b0, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd3, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd4, 3'd5, 0, 0, 0, 0);
        send_sample(1'b0, 3'd1, 3'd3, 0, 0, 0, 0);
        send_sample(1'b0, 3'd5, 3'd6, 0, 5, 3, 0);

        // Train: mode change clears, label change alone does not.
        send_sample(1'b1, 3'd2, 3'd0, 1, 0, 0, 0);
        send_sample(1'b1, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b1, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b1, 3'd2, 3'd0, 0, 2, 0, 0);
        send_sample(1'b1, 3'd7, 3'd0, 0, 0, 0, 0);

        // Two predict samples, then back to train: needs a full new window.
        send_sample(1'b0, 3'd4, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd4, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < NGRAM; i++) begin
            send_sample(1'b1, 3'd3, 3'd0, 0, 0, 0, 0);
        end

        // Reset while waiting for the AM result.
        send_sample(1'b0, 3'd1, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd1, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd1, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd6, 3'd4, 0, 1, 0, 1);

        // Window restarts from fill 1 after the reset.
        send_sample(1'b0, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd2, 3'd0, 0, 0, 0, 0);
        send_sample(1'b0, 3'd0, 3'd7, 0, 0, 1, 0);

        check_val("am_queue_empty", 32'(am_q.size()), 0);
        check_val("out_queue_empty", 32'(out_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
